// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: MDU op codes, MDU FSM encoding, default width.
package mips_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // True for the ops that run the iterative datapath.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// MDU bus: start/op/operands from the datapath, busy/done/hi/lo back.
//   master: drives start, op, rs_val, rt_val; reads busy, done, hi, lo
//   slave : the MDU side
interface mdu_hilo_if #(
  parameter int unsigned WIDTH = mips_pkg::MDU_WIDTH
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, done, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_core.sv
// One radix-2 step per cycle on a shared 2*WIDTH register.
//   load   : capture operands (a = multiplicand/dividend, b = multiplier/divisor)
//   step   : perform one shift-add (mul) or restoring shift-subtract (div)
//   hi_res : product upper half / remainder
//   lo_res : product lower half / quotient
module mdu_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic               div_mode;
  logic [WIDTH:0]     add_sum, shifted, diff;

  // Mul: acc = {partial, multiplier}, right shift. Div: acc = {rem, dividend/quotient}, left shift.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    if (div_mode) begin
      if (diff[WIDTH]) acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_nxt = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      opb      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= {WIDTH'(0), (is_div ? a : b)};
      opb      <= is_div ? b : a;
      div_mode <= is_div;
    end else if (step) begin
      acc      <= acc_nxt;
    end
  end

  assign hi_res = acc[2*WIDTH-1:WIDTH];
  assign lo_res = acc[WIDTH-1:0];

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/op/rs_val/rt_val in; busy/done/hi/lo out (all registered)
module mdu_hilo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] rs_raw;

  logic             accept_c, signed_c, last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0] hi_fix_c, lo_fix_c;

  // Operand conditioning for a new mul/div.
  always_comb begin
    accept_c = (state == ST_IDLE) && bus.start && is_muldiv(bus.op);
    signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_mag_c  = (signed_c && bus.rs_val[WIDTH-1]) ? (~bus.rs_val + WIDTH'(1)) : bus.rs_val;
    b_mag_c  = (signed_c && bus.rt_val[WIDTH-1]) ? (~bus.rt_val + WIDTH'(1)) : bus.rt_val;
    last_c   = (cnt == CNT_W'(WIDTH - 1));
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_c),
    .step   (state == ST_CALC),
    .is_div ((bus.op == OP_DIV) || (bus.op == OP_DIVU)),
    .a      (a_mag_c),
    .b      (b_mag_c),
    .hi_res (core_hi),
    .lo_res (core_lo)
  );

  // Sign correction of the magnitude result; divide by zero bypasses it.
  always_comb begin
    prod_c = {core_hi, core_lo};
    if (neg_q) prod_c = ~prod_c + (2*WIDTH)'(1);
    hi_fix_c = prod_c[2*WIDTH-1:WIDTH];
    lo_fix_c = prod_c[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero) begin
        hi_fix_c = rs_raw;
        lo_fix_c = '1;
      end else begin
        hi_fix_c = neg_r ? (~core_hi + WIDTH'(1)) : core_hi;
        lo_fix_c = neg_q ? (~core_lo + WIDTH'(1)) : core_lo;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept_c) state_nxt = ST_CALC;
      ST_CALC: if (last_c)   state_nxt = ST_FIX;
      ST_FIX:                state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // HI/LO, status flags and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      rs_raw   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                busy_q   <= 1'b1;
                cnt      <= '0;
                is_div_q <= (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                neg_q    <= signed_c && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                neg_r    <= signed_c && bus.rs_val[WIDTH-1];
                div_zero <= (bus.rt_val == '0);
                rs_raw   <= bus.rs_val;
              end
              OP_MTHI: hi_q <= bus.rs_val;
              OP_MTLO: lo_q <= bus.rs_val;
              OP_NOP, OP_RSVD: ;
            endcase
          end
        end
        ST_CALC: cnt <= cnt + CNT_W'(1);
        ST_FIX: begin
          hi_q   <= hi_fix_c;
          lo_q   <= lo_fix_c;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: architectural MIPS results computed with 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    u  = '0;
    case (op)
      OP_MULT:  begin p = sa * sb; u = p; end
      OP_MULTU: u = {32'd0, rs} * {32'd0, rt};
      OP_DIV: begin
        if (rt == 32'd0) u = {rs, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; u = {r[31:0], q[31:0]}; end
      end
      OP_DIVU: begin
        if (rt == 32'd0) u = {rs, 32'hFFFF_FFFF};
        else u = {rs % rt, rs / rt};
      end
      default: u = '0;
    endcase
    hi = u[63:32];
    lo = u[31:0];
  endtask

  // Issue one mul/div, check timing, hold of old HI/LO, result and done width.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    int lat, busyc;
    bit both, got;
    @(negedge clk);
    hi0 = bus.hi; lo0 = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
    lat = 0; busyc = 0; both = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.start  = 1'b0;
        bus.op     = 3'($urandom_range(0, 7));
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
      end
      if (bus.busy) busyc++;
      if (bus.busy && bus.done) both = 1;
      if (lat == 10) chk({name, " hold"}, {bus.hi, bus.lo}, {hi0, lo0});
      if (bus.done) got = 1;
    end
    chk({name, " latency"}, 64'(lat), 64'd34);
    chk({name, " busy_cycles"}, 64'(busyc), 64'd33);
    chk({name, " busy_done_overlap"}, 64'(both), 64'd0);
    chk({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    chk({name, " done_width"}, {62'd0, bus.done, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] ehi, elo, rs, rt;
    logic [2:0]  op;
    int n;
    bit saw;

    vecs.push_back('{"mult_neg3x5",  OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_m1xm1",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{"div_neg7by2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_100by7",  OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14});
    vecs.push_back('{"divu_by0",     OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"div_neg_by0",  OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF});

    bus.start = 1'b0; bus.op = OP_NOP; bus.rs_val = '0; bus.rt_val = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset state", {bus.hi, bus.lo}, 64'd0);
    chk("reset flags", {62'd0, bus.busy, bus.done}, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

    // MTHI then MTLO back to back.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'h1234_5678;
    @(negedge clk);
    chk("mthi hi", 64'(bus.hi), 64'h1234_5678);
    chk("mthi flags", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.op = OP_MTLO; bus.rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
    chk("mtlo hi kept", 64'(bus.hi), 64'h1234_5678);
    chk("mtlo flags", {62'd0, bus.busy, bus.done}, 64'd0);

    // MTHI while a MULT is running must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mthi_busy hi kept", 64'(bus.hi), 64'h1234_5678);
    chk("mthi_busy busy", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.done && n < 60) begin @(negedge clk); n++; end
    chk("mthi_busy done seen", 64'(bus.done), 64'd1);
    chk("mthi_busy hi", 64'(bus.hi), 64'd0);
    chk("mthi_busy lo", 64'(bus.lo), 64'd6);

    // Reset in the middle of a DIVU aborts without a commit.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst flags", {62'd0, bus.busy, bus.done}, 64'd0);
    rst = 1'b0;
    saw = 0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) saw = 1; end
    chk("midrst no done", 64'(saw), 64'd0);
    run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42);

    // Randomized mul/div against the reference model.
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(1, 4));
      rs = $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(1, 15));
        2: rt = 32'hFFFF_FFFF;
        default: rt = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rs = 32'h8000_0000;
      model(op, rs, rt, ehi, elo);
      run_op($sformatf("rand%0d_op%0d", k, op), op, rs, rt, ehi, elo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
